// File: rtl/alu_operand_ctrl.sv
// alu_operand_ctrl: sequencer between the shared data bus and a combinational ALU.
// It latches the operands, runs one ALU operation per start, captures the result
// and flags, and returns the result to the bus on request.
// Optional feature macro: ALU_CARRY_CHAIN_EN feeds the captured carry back as the
// ALU carry-in, which allows multiword add-with-carry.
module alu_operand_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             load_a,
    input  logic             load_b,
    input  logic [2:0]       op,
    input  logic             start,
    input  logic             flag_clr,
    input  logic             result_oe,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             alu_carry,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] alu_in_1,
    output logic [WIDTH-1:0] alu_in_2,
    output logic [2:0]       alu_select,
    output logic             alu_enable,
    output logic             alu_carry_in,
    output logic [WIDTH-1:0] bus_out,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q, res_q;
    logic [2:0]         op_q;
    logic               carry_q, zero_q, done_q;
    logic               idle, capture;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state: one operation walks IDLE -> EXEC -> CAPTURE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_EXEC;
            S_EXEC:    state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; alu_enable follows the async reset at once.
    always_comb begin
        idle       = (state_q == S_IDLE);
        capture    = (state_q == S_CAPTURE);
        alu_enable = (state_q == S_EXEC) || capture;
        busy       = !idle;
    end

    // Operand and op registers; only written while idle, so requests during an
    // operation are dropped rather than queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
        end else if (idle) begin
            if (load_a) a_q  <= bus_in;
            if (load_b) b_q  <= bus_in;
            if (start)  op_q <= op;
        end
    end

    // Result/flag capture; a capture on the same edge as flag_clr takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (capture) begin
            res_q   <= alu_data;
            carry_q <= alu_carry;
            zero_q  <= alu_zero;
        end else if (flag_clr) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end
    end

    // done pulses for the single cycle after the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done_q <= 1'b0;
        else        done_q <= capture;
    end

    assign alu_in_1   = a_q;
    assign alu_in_2   = b_q;
    assign alu_select = op_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;
    assign done       = done_q;
    assign bus_out    = result_oe ? res_q : {WIDTH{1'bz}};

`ifdef ALU_CARRY_CHAIN_EN
    assign alu_carry_in = carry_q;
`else
    assign alu_carry_in = 1'b0;
`endif

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Self-checking bench for alu_operand_ctrl. The bench owns a small behavioural
// ALU (0 add+cin, 1 sub with borrow as carry, 2 and, 3 or, 4 xor, 6 inc A).
module tb_alu_operand_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bus_in;
    logic        load_a, load_b, start, flag_clr, result_oe;
    logic [2:0]  op;
    logic [15:0] alu_data;
    logic        alu_carry, alu_zero;
    logic [15:0] alu_in_1, alu_in_2;
    logic [2:0]  alu_select;
    logic        alu_enable, alu_carry_in;
    wire  [15:0] bus_out;
    logic        carry_flag, zero_flag, busy, done;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_operand_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .load_a(load_a), .load_b(load_b),
        .op(op), .start(start), .flag_clr(flag_clr), .result_oe(result_oe),
        .alu_data(alu_data), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_select(alu_select),
        .alu_enable(alu_enable), .alu_carry_in(alu_carry_in), .bus_out(bus_out),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .busy(busy), .done(done)
    );

    // Behavioural ALU driven by the DUT's operand/select lines.
    logic [16:0] r17;
    always_comb begin
        r17 = '0;
        case (alu_select)
            3'd0:    r17 = {1'b0, alu_in_1} + {1'b0, alu_in_2} + {16'd0, alu_carry_in};
            3'd1:    r17 = {1'b0, alu_in_1} - {1'b0, alu_in_2};
            3'd2:    r17 = {1'b0, alu_in_1 & alu_in_2};
            3'd3:    r17 = {1'b0, alu_in_1 | alu_in_2};
            3'd4:    r17 = {1'b0, alu_in_1 ^ alu_in_2};
            3'd6:    r17 = {1'b0, alu_in_1} + 17'd1;
            default: r17 = {1'b0, alu_in_1};
        endcase
        alu_data  = r17[15:0];
        alu_carry = r17[16];
        alu_zero  = (r17[15:0] == 16'd0);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Load A alone, then load B together with start; returns at the negedge in EXEC.
    task automatic load_and_start(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
        @(negedge clk); bus_in = a; load_a = 1'b1;
        @(negedge clk); load_a = 1'b0; bus_in = b; load_b = 1'b1; start = 1'b1; op = o;
        @(negedge clk); load_b = 1'b0; start = 1'b0; bus_in = 16'h0;
    endtask

    task automatic chk_bus(input string name, input logic [15:0] exp);
        result_oe = 1'b1; #1;
        chk(name, {16'd0, bus_out}, {16'd0, exp});
        result_oe = 1'b0; #1;
        // A released bus reads z on 4-state nets, 0 where nets are 2-state.
        nchk++;
        if (bus_out !== 16'hzzzz && bus_out !== 16'h0000) begin
            nerr++;
            $display("FAIL %s_release: got %h expected zzzz", name, bus_out);
        end
    endtask

    initial begin
        int dones;
        vecs[0] = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b1};
        vecs[1] = '{16'h0005, 16'h0007, 3'd1, 16'hFFFE, 1'b1, 1'b0};
`ifdef ALU_CARRY_CHAIN_EN
        vecs[2] = '{16'hFFFF, 16'h0001, 3'd0, 16'h0001, 1'b1, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 3'd0, 16'h0001, 1'b0, 1'b0};
`else
        vecs[2] = '{16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b0, 1'b1};
`endif
        vecs[4] = '{16'hF0F0, 16'hFF00, 3'd2, 16'hF000, 1'b0, 1'b0};
        vecs[5] = '{16'hF0F0, 16'h0F0F, 3'd3, 16'hFFFF, 1'b0, 1'b0};
        vecs[6] = '{16'hAAAA, 16'hAAAA, 3'd4, 16'h0000, 1'b0, 1'b1};
        vecs[7] = '{16'h00FF, 16'h0000, 3'd6, 16'h0100, 1'b0, 1'b0};

        rst_n = 1'b0; bus_in = '0; load_a = 0; load_b = 0; start = 0; op = '0;
        flag_clr = 0; result_oe = 1'b1;
        #12;
        chk("rst_bus_out", {16'd0, bus_out}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_enable", {31'd0, alu_enable}, 32'h0);
        chk("rst_done", {31'd0, done}, 32'h0);
        chk("rst_flags", {30'd0, carry_flag, zero_flag}, 32'h0);
        chk("rst_ops", {alu_in_1, alu_in_2}, 32'h0);
        result_oe = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        // Table: EXEC and CAPTURE each last one cycle, done follows.
        for (int i = 0; i < 8; i++) begin
            load_and_start(vecs[i].a, vecs[i].b, vecs[i].op);
            chk($sformatf("v%0d_exec_busy", i), {29'd0, busy, alu_enable, done}, 32'h6);
            chk($sformatf("v%0d_b_with_start", i), {16'd0, alu_in_2}, {16'd0, vecs[i].b});
            @(negedge clk);
            chk($sformatf("v%0d_capt_busy", i), {29'd0, busy, alu_enable, done}, 32'h6);
            @(negedge clk);
            chk($sformatf("v%0d_done", i), {29'd0, busy, alu_enable, done}, 32'h1);
            chk($sformatf("v%0d_flags", i), {30'd0, carry_flag, zero_flag},
                {30'd0, vecs[i].c, vecs[i].z});
            chk($sformatf("v%0d_a", i), {16'd0, alu_in_1}, {16'd0, vecs[i].a});
            chk_bus($sformatf("v%0d_result", i), vecs[i].res);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'h0);
        end

        // Both loads together put the same bus value in A and B.
        @(negedge clk); bus_in = 16'h5A5A; load_a = 1'b1; load_b = 1'b1;
        @(negedge clk); load_a = 1'b0; load_b = 1'b0;
        chk("both_loads", {alu_in_1, alu_in_2}, 32'h5A5A5A5A);

        // Requests while busy are ignored; exactly one done pulse.
        load_and_start(16'h1111, 16'h2222, 3'd3);
        bus_in = 16'h1234; load_a = 1'b1; start = 1'b1; op = 3'd0;
        @(negedge clk); load_a = 1'b0; start = 1'b0;
        dones = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("busy_done_count", dones, 1);
        chk("busy_load_ignored", {16'd0, alu_in_1}, 32'h1111);
        chk("busy_op_ignored", {29'd0, alu_select}, 32'h3);
        chk_bus("busy_result", 16'h3333);

        // Reset during CAPTURE: immediate idle, flags cleared, no done.
        load_and_start(16'hFFFF, 16'h0001, 3'd0);
        @(negedge clk); @(negedge clk);
        chk("pre_rst_flags", {30'd0, carry_flag, zero_flag}, 32'h3);
`ifdef ALU_CARRY_CHAIN_EN
        chk("chain_cin", {31'd0, alu_carry_in}, 32'h1);
`else
        chk("chain_cin", {31'd0, alu_carry_in}, 32'h0);
`endif
        load_and_start(16'hFFFF, 16'h0001, 3'd0);
        @(negedge clk);
        chk("capt_before_rst", {30'd0, busy, alu_enable}, 32'h3);
        #2 rst_n = 1'b0; #1;
        chk("rst_mid_enable_busy", {30'd0, busy, alu_enable}, 32'h0);
        chk("rst_mid_flags", {30'd0, carry_flag, zero_flag}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_mid_no_done", dones, 0);
        load_and_start(16'h00FF, 16'h0000, 3'd6);
        @(negedge clk); @(negedge clk);
        chk("post_rst_done", {31'd0, done}, 32'h1);
        chk_bus("post_rst_inc", 16'h0100);

        // flag_clr on the capture edge loses; on a later idle edge it clears.
        load_and_start(16'hFFFF, 16'h0001, 3'd0);
        @(negedge clk); flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        chk("clr_vs_capture", {30'd0, carry_flag, zero_flag}, 32'h3);
        flag_clr = 1'b1;
        @(negedge clk); flag_clr = 1'b0;
        chk("clr_idle", {30'd0, carry_flag, zero_flag}, 32'h0);
        chk_bus("clr_keeps_result", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
